// File: rtl/teclado_clave.sv
// Keypad PIN entry: debounced key presses become a two-digit BCD code with backspace/cancel/enter handling.
// Latency: a key event at edge N is visible on all registered outputs after edge N. No backpressure; the strobes last one cycle.
// With TECLADO_TIMEOUT_EN defined, an idle partial entry is dropped after TIMEOUT_CICLOS cycles.
module teclado_clave
`ifdef TECLADO_TIMEOUT_EN
  #(parameter int TIMEOUT_CICLOS = 1000)
`endif
(
  input  logic       clock,
  input  logic       reset,
  input  logic       sensor_llegada_vehiculo,
  input  logic       tecla_presionada,
  input  logic [3:0] codigo_tecla,
  output logic [7:0] clave_ingresada,
  output logic       clave_valida,
  output logic [1:0] digitos_ingresados,
  output logic       error_tecla
);

  typedef enum logic [1:0] {ESPERA, VACIA, UN_DIGITO, DOS_DIGITOS} estado_t;

  localparam logic [3:0] TECLA_BORRAR   = 4'hA;
  localparam logic [3:0] TECLA_ENTER    = 4'hB;
  localparam logic [3:0] TECLA_CANCELAR = 4'hC;

  estado_t    estado;
  logic [7:0] buffer;
  logic       tecla_previa;
  logic       evento;
  logic       es_digito;
  logic       entrada_parcial;
  logic       expira;

  assign evento          = tecla_presionada & ~tecla_previa;
  assign es_digito       = (codigo_tecla <= 4'd9);
  assign entrada_parcial = (estado == UN_DIGITO) || (estado == DOS_DIGITOS);

`ifdef TECLADO_TIMEOUT_EN
  localparam logic [15:0] LIMITE = 16'(TIMEOUT_CICLOS - 1);

  logic [15:0] contador;

  // A key event on the expiry cycle wins, so it suppresses the timeout.
  assign expira = entrada_parcial && !evento && (contador == LIMITE);

  always_ff @(posedge clock) begin
    if (reset) begin
      contador <= '0;
    end else if (!sensor_llegada_vehiculo || evento || expira || !entrada_parcial) begin
      contador <= '0;
    end else begin
      contador <= contador + 16'd1;
    end
  end
`else
  assign expira = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      estado             <= ESPERA;
      buffer             <= 8'h00;
      tecla_previa       <= 1'b0;
      clave_ingresada    <= 8'h00;
      clave_valida       <= 1'b0;
      digitos_ingresados <= 2'd0;
      error_tecla        <= 1'b0;
    end else begin
      tecla_previa <= tecla_presionada;
      clave_valida <= 1'b0;
      error_tecla  <= 1'b0;

      if (estado != ESPERA && !sensor_llegada_vehiculo) begin
        estado             <= ESPERA;
        buffer             <= 8'h00;
        digitos_ingresados <= 2'd0;
      end else begin
        case (estado)
          ESPERA: begin
            if (sensor_llegada_vehiculo) begin
              estado <= VACIA;
            end
          end

          default: begin
            if (evento) begin
              if (es_digito) begin
                case (estado)
                  VACIA: begin
                    buffer[7:4]        <= codigo_tecla;
                    estado             <= UN_DIGITO;
                    digitos_ingresados <= 2'd1;
                  end
                  UN_DIGITO: begin
                    buffer[3:0]        <= codigo_tecla;
                    estado             <= DOS_DIGITOS;
                    digitos_ingresados <= 2'd2;
                  end
                  default: begin
                    error_tecla <= 1'b1;
                  end
                endcase
              end else begin
                case (codigo_tecla)
                  TECLA_BORRAR: begin
                    if (estado == DOS_DIGITOS) begin
                      buffer[3:0]        <= 4'h0;
                      estado             <= UN_DIGITO;
                      digitos_ingresados <= 2'd1;
                    end else if (estado == UN_DIGITO) begin
                      buffer[7:4]        <= 4'h0;
                      estado             <= VACIA;
                      digitos_ingresados <= 2'd0;
                    end
                  end
                  TECLA_ENTER: begin
                    if (estado == DOS_DIGITOS) begin
                      clave_ingresada    <= buffer;
                      clave_valida       <= 1'b1;
                      buffer             <= 8'h00;
                      estado             <= VACIA;
                      digitos_ingresados <= 2'd0;
                    end else begin
                      error_tecla <= 1'b1;
                    end
                  end
                  TECLA_CANCELAR: begin
                    buffer             <= 8'h00;
                    estado             <= VACIA;
                    digitos_ingresados <= 2'd0;
                  end
                  default: begin
                  end
                endcase
              end
            end else if (expira) begin
              buffer             <= 8'h00;
              estado             <= VACIA;
              digitos_ingresados <= 2'd0;
              error_tecla        <= 1'b1;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_teclado_clave.sv
// Bench for teclado_clave: directed scenarios plus random key traffic against a digit-queue reference model.
module tb_teclado_clave;
`ifdef TECLADO_TIMEOUT_EN
  localparam int TO = 10;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       sensor = 1'b0;
  logic       tecla = 1'b0;
  logic [3:0] codigo = 4'h0;
  logic [7:0] clave_ingresada;
  logic       clave_valida;
  logic [1:0] digitos_ingresados;
  logic       error_tecla;

  int errors = 0;
  int checks = 0;
  int n_valida = 0;
  int n_error = 0;

  // Reference model: gate status, queue of buffered digits, last submitted code.
  bit         m_espera = 1'b1;
  int         m_q[$];
  logic [7:0] m_clave = 8'h00;
  bit         m_valida = 1'b0;
  bit         m_error = 1'b0;
  bit         m_prev = 1'b0;
`ifdef TECLADO_TIMEOUT_EN
  int         m_idle = 0;
`endif

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (clave_valida) n_valida++;
    if (error_tecla) n_error++;
  end

`ifdef TECLADO_TIMEOUT_EN
  teclado_clave #(.TIMEOUT_CICLOS(TO)) dut (
`else
  teclado_clave dut (
`endif
    .clock(clock),
    .reset(reset),
    .sensor_llegada_vehiculo(sensor),
    .tecla_presionada(tecla),
    .codigo_tecla(codigo),
    .clave_ingresada(clave_ingresada),
    .clave_valida(clave_valida),
    .digitos_ingresados(digitos_ingresados),
    .error_tecla(error_tecla)
  );

  function automatic logic [1:0] m_count();
    return m_espera ? 2'd0 : 2'(m_q.size());
  endfunction

  // Advances the model by one clock edge using the current inputs, then clocks the DUT.
  task automatic step();
    bit ev;
    ev = tecla && !m_prev;
    m_valida = 1'b0;
    m_error  = 1'b0;
    if (reset) begin
      m_espera = 1'b1;
      m_q.delete();
      m_clave = 8'h00;
`ifdef TECLADO_TIMEOUT_EN
      m_idle = 0;
`endif
    end else if (!sensor) begin
      m_espera = 1'b1;
      m_q.delete();
`ifdef TECLADO_TIMEOUT_EN
      m_idle = 0;
`endif
    end else if (m_espera) begin
      m_espera = 1'b0;
    end else if (ev) begin
`ifdef TECLADO_TIMEOUT_EN
      m_idle = 0;
`endif
      if (codigo <= 4'd9) begin
        if (m_q.size() < 2) m_q.push_back(int'(codigo));
        else m_error = 1'b1;
      end else if (codigo == 4'hA) begin
        if (m_q.size() > 0) void'(m_q.pop_back());
      end else if (codigo == 4'hB) begin
        if (m_q.size() == 2) begin
          m_clave  = {4'(m_q[0]), 4'(m_q[1])};
          m_valida = 1'b1;
          m_q.delete();
        end else begin
          m_error = 1'b1;
        end
      end else if (codigo == 4'hC) begin
        m_q.delete();
      end
    end else if (m_q.size() > 0) begin
`ifdef TECLADO_TIMEOUT_EN
      m_idle++;
      if (m_idle == TO) begin
        m_q.delete();
        m_error = 1'b1;
        m_idle  = 0;
      end
`endif
    end
    m_prev = reset ? 1'b0 : tecla;
    @(posedge clock);
    #1;
  endtask

  task automatic key_down(input logic [3:0] k);
    codigo = k;
    tecla  = 1'b1;
    step();
  endtask

  task automatic key_up();
    tecla = 1'b0;
    step();
  endtask

  task automatic test_reset();
    reset = 1'b1; sensor = 1'b0; tecla = 1'b0;
    step(); step();
    reset = 1'b0;
    checks++; if (clave_ingresada !== 8'h00) begin errors++; $display("FAIL reset_clave got=%h exp=00", clave_ingresada); end
    checks++; if (clave_valida !== 1'b0) begin errors++; $display("FAIL reset_valida got=%b exp=0", clave_valida); end
    checks++; if (digitos_ingresados !== 2'd0) begin errors++; $display("FAIL reset_digitos got=%0d exp=0", digitos_ingresados); end
    checks++; if (error_tecla !== 1'b0) begin errors++; $display("FAIL reset_error got=%b exp=0", error_tecla); end
  endtask

  task automatic test_normal();
    sensor = 1'b1;
    step();
    key_down(4'h4);
    checks++; if (digitos_ingresados !== 2'd1) begin errors++; $display("FAIL normal_d1 got=%0d exp=1", digitos_ingresados); end
    key_up();
    key_down(4'h7);
    checks++; if (digitos_ingresados !== 2'd2) begin errors++; $display("FAIL normal_d2 got=%0d exp=2", digitos_ingresados); end
    key_up();
    key_down(4'hB);
    checks++; if (clave_ingresada !== 8'h47) begin errors++; $display("FAIL normal_clave got=%h exp=47", clave_ingresada); end
    checks++; if (clave_valida !== 1'b1) begin errors++; $display("FAIL normal_valida got=%b exp=1", clave_valida); end
    checks++; if (digitos_ingresados !== 2'd0) begin errors++; $display("FAIL normal_d0 got=%0d exp=0", digitos_ingresados); end
    key_up();
    checks++; if (clave_valida !== 1'b0) begin errors++; $display("FAIL normal_valida_width got=%b exp=0", clave_valida); end
    checks++; if (clave_ingresada !== 8'h47) begin errors++; $display("FAIL normal_hold got=%h exp=47", clave_ingresada); end
  endtask

  task automatic test_backspace();
    int v0, e0;
    v0 = n_valida; e0 = n_error;
    key_down(4'h4); key_up();
    key_down(4'h7); key_up();
    key_down(4'hA);
    checks++; if (digitos_ingresados !== 2'd1) begin errors++; $display("FAIL bksp_digitos got=%0d exp=1", digitos_ingresados); end
    key_up();
    key_down(4'h2); key_up();
    key_down(4'hB);
    checks++; if (clave_ingresada !== 8'h42) begin errors++; $display("FAIL bksp_clave got=%h exp=42", clave_ingresada); end
    key_up();
    checks++; if (n_valida - v0 !== 1) begin errors++; $display("FAIL bksp_valida_count got=%0d exp=1", n_valida - v0); end
    checks++; if (n_error - e0 !== 0) begin errors++; $display("FAIL bksp_error_count got=%0d exp=0", n_error - e0); end
  endtask

  task automatic test_illegal();
    key_down(4'h5); key_up();
    key_down(4'hB);
    checks++; if (error_tecla !== 1'b1) begin errors++; $display("FAIL early_enter_error got=%b exp=1", error_tecla); end
    checks++; if (digitos_ingresados !== 2'd1) begin errors++; $display("FAIL early_enter_digitos got=%0d exp=1", digitos_ingresados); end
    key_up();
    checks++; if (error_tecla !== 1'b0) begin errors++; $display("FAIL early_enter_width got=%b exp=0", error_tecla); end
    key_down(4'hC); key_up();
    checks++; if (digitos_ingresados !== 2'd0) begin errors++; $display("FAIL cancel_digitos got=%0d exp=0", digitos_ingresados); end
    key_down(4'h1); key_up();
    key_down(4'h2); key_up();
    key_down(4'h3);
    checks++; if (error_tecla !== 1'b1) begin errors++; $display("FAIL third_digit_error got=%b exp=1", error_tecla); end
    checks++; if (digitos_ingresados !== 2'd2) begin errors++; $display("FAIL third_digit_digitos got=%0d exp=2", digitos_ingresados); end
    key_up();
    key_down(4'hB);
    checks++; if (clave_ingresada !== 8'h12) begin errors++; $display("FAIL third_digit_buffer got=%h exp=12", clave_ingresada); end
    checks++; if (clave_valida !== 1'b1) begin errors++; $display("FAIL third_digit_valida got=%b exp=1", clave_valida); end
    key_up();
  endtask

  task automatic test_sensor();
    int v0, e0;
    key_down(4'h9); key_up();
    sensor = 1'b0;
    step();
    checks++; if (digitos_ingresados !== 2'd0) begin errors++; $display("FAIL loss_digitos got=%0d exp=0", digitos_ingresados); end
    checks++; if (clave_ingresada !== 8'h12) begin errors++; $display("FAIL loss_clave got=%h exp=12", clave_ingresada); end
    v0 = n_valida; e0 = n_error;
    key_down(4'h1); key_up();
    key_down(4'h2); key_up();
    key_down(4'hB); key_up();
    checks++; if ((n_valida - v0) + (n_error - e0) !== 0) begin errors++; $display("FAIL espera_strobes got=%0d exp=0", (n_valida - v0) + (n_error - e0)); end
    checks++; if (digitos_ingresados !== 2'd0) begin errors++; $display("FAIL espera_digitos got=%0d exp=0", digitos_ingresados); end
    sensor = 1'b1;
    step();
    key_down(4'h8); key_up();
    sensor = 1'b0;
    key_down(4'hB);
    checks++; if (error_tecla !== 1'b0 || digitos_ingresados !== 2'd0) begin errors++; $display("FAIL loss_vs_key got err=%b dig=%0d exp err=0 dig=0", error_tecla, digitos_ingresados); end
    key_up();
    sensor = 1'b1;
    step();
  endtask

  task automatic test_timeout();
    int e0;
    e0 = n_error;
    key_down(4'h3); key_up();
`ifdef TECLADO_TIMEOUT_EN
    repeat (TO - 2) step();
    checks++; if (digitos_ingresados !== 2'd1 || n_error !== e0) begin errors++; $display("FAIL to_early got dig=%0d errs=%0d exp dig=1 errs=%0d", digitos_ingresados, n_error, e0); end
    step();
    checks++; if (error_tecla !== 1'b1) begin errors++; $display("FAIL to_error got=%b exp=1", error_tecla); end
    checks++; if (digitos_ingresados !== 2'd0) begin errors++; $display("FAIL to_digitos got=%0d exp=0", digitos_ingresados); end
    step();
    checks++; if (error_tecla !== 1'b0) begin errors++; $display("FAIL to_width got=%b exp=0", error_tecla); end
    key_down(4'h3); key_up();
    repeat (TO - 2) step();
    key_down(4'h4);
    checks++; if (digitos_ingresados !== 2'd2 || error_tecla !== 1'b0) begin errors++; $display("FAIL to_key_wins got dig=%0d err=%b exp dig=2 err=0", digitos_ingresados, error_tecla); end
    key_up();
`else
    repeat (1200) step();
    checks++; if (digitos_ingresados !== 2'd1 || n_error !== e0) begin errors++; $display("FAIL no_timeout got dig=%0d errs=%0d exp dig=1 errs=%0d", digitos_ingresados, n_error, e0); end
`endif
    key_down(4'hC); key_up();
  endtask

  task automatic test_held();
    int v0, e0;
    v0 = n_valida; e0 = n_error;
    key_down(4'h6);
    repeat (49) step();
    checks++; if (digitos_ingresados !== 2'd1) begin errors++; $display("FAIL held_digitos got=%0d exp=1", digitos_ingresados); end
    key_up();
    key_down(4'hC); key_up();
    codigo = 4'h5; tecla = 1'b1; reset = 1'b1;
    step(); step();
    reset = 1'b0;
    repeat (5) step();
    checks++; if (digitos_ingresados !== 2'd0) begin errors++; $display("FAIL reset_held_digitos got=%0d exp=0", digitos_ingresados); end
    key_up();
    checks++; if ((n_valida - v0) + (n_error - e0) !== 0) begin errors++; $display("FAIL held_strobes got=%0d exp=0", (n_valida - v0) + (n_error - e0)); end
    key_down(4'h5);
    checks++; if (digitos_ingresados !== 2'd1) begin errors++; $display("FAIL after_reset_key got=%0d exp=1", digitos_ingresados); end
    key_up();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      int gap;
      int r;
      gap = $urandom_range(1, 12);
      r = $urandom_range(0, 19);
      if (r <= 9) codigo = 4'(r);
      else if (r <= 11) codigo = 4'hA;
      else if (r <= 15) codigo = 4'hB;
      else if (r <= 17) codigo = 4'hC;
      else codigo = 4'($urandom_range(13, 15));
      tecla = 1'b1;
      if ($urandom_range(0, 11) == 0) sensor = ~sensor;
      if ($urandom_range(0, 99) == 0) reset = 1'b1;
      for (int c = 0; c <= gap; c++) begin
        if (c == 1) begin
          tecla = 1'b0;
          reset = 1'b0;
        end
        step();
        checks++;
        if (clave_ingresada !== m_clave || clave_valida !== m_valida ||
            digitos_ingresados !== m_count() || error_tecla !== m_error) begin
          errors++;
          $display("FAIL random it=%0d cyc=%0d got clave=%h val=%b dig=%0d err=%b exp clave=%h val=%b dig=%0d err=%b",
                   i, c, clave_ingresada, clave_valida, digitos_ingresados, error_tecla,
                   m_clave, m_valida, m_count(), m_error);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_backspace();
    test_illegal();
    test_sensor();
    test_timeout();
    test_held();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
